// File: rtl/wb_stage_multi_if.sv
// Execute-to-writeback handshake plus register-file write ports for wb_stage_multi.
interface wb_stage_multi_if #(
  parameter int NUM_LANES  = 2,
  parameter int NUM_WPORTS = 2,
  parameter int XLEN       = 32,
  parameter int REG_AW     = 5
);
  localparam int LW = 1 + REG_AW + 2 * XLEN;

  logic                         flush;
  logic [NUM_LANES-1:0]         es_to_ws_valid;
  logic [NUM_LANES*LW-1:0]      es_to_ws_bus;
  logic                         ws_allowin;
  logic [NUM_WPORTS-1:0]        rf_we;
  logic [NUM_WPORTS*REG_AW-1:0] rf_waddr;
  logic [NUM_WPORTS*XLEN-1:0]   rf_wdata;
  logic [NUM_WPORTS*XLEN-1:0]   rf_pc;
  logic                         ws_busy;

  modport master (
    output flush, es_to_ws_valid, es_to_ws_bus,
    input  ws_allowin, rf_we, rf_waddr, rf_wdata, rf_pc, ws_busy
  );

  modport slave (
    input  flush, es_to_ws_valid, es_to_ws_bus,
    output ws_allowin, rf_we, rf_waddr, rf_wdata, rf_pc, ws_busy
  );
endinterface

// File: rtl/wb_stage_multi.sv
// Multi-lane writeback stage: holds one issue group and drains its register writes
// through NUM_WPORTS ports, oldest lanes first, with intra-group WAW squash.
module wb_stage_multi #(
  parameter int NUM_LANES  = 2,
  parameter int NUM_WPORTS = 2,
  parameter int XLEN       = 32,
  parameter int REG_AW     = 5
) (
  input logic clk,
  input logic reset,
  wb_stage_multi_if.slave ws
);
  localparam int LW = 1 + REG_AW + 2 * XLEN;

  logic                         r_ws_valid;
  logic [NUM_LANES-1:0]         r_pend;
  logic [REG_AW-1:0]            r_dest   [NUM_LANES];
  logic [XLEN-1:0]              r_result [NUM_LANES];
  logic [XLEN-1:0]              r_pc     [NUM_LANES];

  logic [NUM_LANES-1:0]         w_in_we;
  logic [REG_AW-1:0]            w_in_dest   [NUM_LANES];
  logic [XLEN-1:0]              w_in_result [NUM_LANES];
  logic [XLEN-1:0]              w_in_pc     [NUM_LANES];
  logic [NUM_LANES-1:0]         w_squash;
  logic [NUM_LANES-1:0]         w_cap_pend;
  logic [NUM_LANES-1:0]         w_grant;
  logic [NUM_WPORTS-1:0]        w_rf_we;
  logic [NUM_WPORTS*REG_AW-1:0] w_rf_waddr;
  logic [NUM_WPORTS*XLEN-1:0]   w_rf_wdata;
  logic [NUM_WPORTS*XLEN-1:0]   w_rf_pc;
  logic                         w_ready_go;
  logic                         w_allowin;
  logic                         w_capture;

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      w_in_pc[i]     = ws.es_to_ws_bus[i*LW +: XLEN];
      w_in_result[i] = ws.es_to_ws_bus[i*LW + XLEN +: XLEN];
      w_in_dest[i]   = ws.es_to_ws_bus[i*LW + 2*XLEN +: REG_AW];
      w_in_we[i]     = ws.es_to_ws_bus[i*LW + 2*XLEN + REG_AW];
    end
  end

  // Youngest writer of a register wins; older lanes aimed at the same dest are dropped.
  always_comb begin
    w_squash   = '0;
    w_cap_pend = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      for (int j = i + 1; j < NUM_LANES; j++) begin
        if (ws.es_to_ws_valid[j] && w_in_we[j] && (w_in_dest[j] == w_in_dest[i]))
          w_squash[i] = 1'b1;
      end
      w_cap_pend[i] = ws.es_to_ws_valid[i] && w_in_we[i] && (w_in_dest[i] != '0) && !w_squash[i];
    end
  end

  // Reset also masks grants so nothing reaches the register file once it asserts.
  always_comb begin
    int cnt;
    cnt        = 0;
    w_grant    = '0;
    w_rf_we    = '0;
    w_rf_waddr = '0;
    w_rf_wdata = '0;
    w_rf_pc    = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (r_ws_valid && !ws.flush && !reset && r_pend[i] && (cnt < NUM_WPORTS)) begin
        w_grant[i]                         = 1'b1;
        w_rf_we[cnt]                       = 1'b1;
        w_rf_waddr[cnt*REG_AW +: REG_AW]   = r_dest[i];
        w_rf_wdata[cnt*XLEN +: XLEN]       = r_result[i];
        w_rf_pc[cnt*XLEN +: XLEN]          = r_pc[i];
        cnt                                = cnt + 1;
      end
    end
  end

  assign w_ready_go = ((r_pend & ~w_grant) == '0);
  assign w_allowin  = !r_ws_valid || w_ready_go;
  assign w_capture  = w_allowin && !ws.flush && (|ws.es_to_ws_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ws_valid <= 1'b0;
      r_pend     <= '0;
    end else if (w_allowin) begin
      if (w_capture) begin
        r_ws_valid <= 1'b1;
        r_pend     <= w_cap_pend;
      end else begin
        r_ws_valid <= 1'b0;
        r_pend     <= '0;
      end
    end else if (ws.flush) begin
      r_ws_valid <= 1'b0;
      r_pend     <= '0;
    end else begin
      r_pend <= r_pend & ~w_grant;
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        r_dest[i]   <= w_in_dest[i];
        r_result[i] <= w_in_result[i];
        r_pc[i]     <= w_in_pc[i];
      end
    end
  end

  assign ws.ws_allowin = w_allowin;
  assign ws.ws_busy    = r_ws_valid;
  assign ws.rf_we      = w_rf_we;
  assign ws.rf_waddr   = w_rf_waddr;
  assign ws.rf_wdata   = w_rf_wdata;
  assign ws.rf_pc      = w_rf_pc;
endmodule

// File: tb/tb_wb_stage_multi.sv
// Directed bench for wb_stage_multi: three configurations (2x2, 4x2, 4x1) checked with immediate assertions.
module tb_wb_stage_multi;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int LW     = 1 + REG_AW + 2 * XLEN;

  logic clk;
  logic rst_a, rst_b, rst_c;
  int   total;
  int   bad;

  wb_stage_multi_if #(.NUM_LANES(2), .NUM_WPORTS(2), .XLEN(XLEN), .REG_AW(REG_AW)) if_a ();
  wb_stage_multi_if #(.NUM_LANES(4), .NUM_WPORTS(2), .XLEN(XLEN), .REG_AW(REG_AW)) if_b ();
  wb_stage_multi_if #(.NUM_LANES(4), .NUM_WPORTS(1), .XLEN(XLEN), .REG_AW(REG_AW)) if_c ();

  wb_stage_multi #(.NUM_LANES(2), .NUM_WPORTS(2), .XLEN(XLEN), .REG_AW(REG_AW))
    u_a (.clk(clk), .reset(rst_a), .ws(if_a.slave));
  wb_stage_multi #(.NUM_LANES(4), .NUM_WPORTS(2), .XLEN(XLEN), .REG_AW(REG_AW))
    u_b (.clk(clk), .reset(rst_b), .ws(if_b.slave));
  wb_stage_multi #(.NUM_LANES(4), .NUM_WPORTS(1), .XLEN(XLEN), .REG_AW(REG_AW))
    u_c (.clk(clk), .reset(rst_c), .ws(if_c.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [LW-1:0] lane(input logic we, input logic [REG_AW-1:0] dest,
                                         input logic [XLEN-1:0] res, input logic [XLEN-1:0] pc);
    return {we, dest, res, pc};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    if_a.flush = 1'b0; if_a.es_to_ws_valid = '0; if_a.es_to_ws_bus = '0;
    if_b.flush = 1'b0; if_b.es_to_ws_valid = '0; if_b.es_to_ws_bus = '0;
    if_c.flush = 1'b0; if_c.es_to_ws_valid = '0; if_c.es_to_ws_bus = '0;
    repeat (2) nxt();
    #1;
    chk("rst_a_allowin", if_a.ws_allowin, 1'b1);
    chk("rst_a_busy",    if_a.ws_busy,    1'b0);
    chk("rst_a_we",      if_a.rf_we,      2'b00);
    chk("rst_b_allowin", if_b.ws_allowin, 1'b1);
    chk("rst_c_busy",    if_c.ws_busy,    1'b0);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    // 1: same-dest pair, younger lane wins, one write
    nxt();
    if_a.es_to_ws_valid = 2'b11;
    if_a.es_to_ws_bus   = {lane(1'b1, 5'd5, 32'h22, 32'h1004), lane(1'b1, 5'd5, 32'h11, 32'h1000)};
    nxt();
    if_a.es_to_ws_valid = 2'b00;
    #1;
    chk("t1_we",      if_a.rf_we,      2'b01);
    chk("t1_waddr",   if_a.rf_waddr,   10'h005);
    chk("t1_wdata",   if_a.rf_wdata,   64'h22);
    chk("t1_pc",      if_a.rf_pc,      64'h1004);
    chk("t1_allowin", if_a.ws_allowin, 1'b1);
    chk("t1_busy",    if_a.ws_busy,    1'b1);
    nxt(); #1;
    chk("t1_retired", if_a.ws_busy,    1'b0);
    chk("t1_idle_we", if_a.rf_we,      2'b00);

    // 2: lane0 invalid must neither write nor block
    if_a.es_to_ws_valid = 2'b10;
    if_a.es_to_ws_bus   = {lane(1'b1, 5'd3, 32'hAB, 32'h104), lane(1'b1, 5'd7, 32'h77, 32'h100)};
    nxt();
    if_a.es_to_ws_valid = 2'b00;
    #1;
    chk("t2_we",      if_a.rf_we,      2'b01);
    chk("t2_waddr",   if_a.rf_waddr,   10'h003);
    chk("t2_wdata",   if_a.rf_wdata,   64'hAB);
    chk("t2_pc",      if_a.rf_pc,      64'h104);
    chk("t2_allowin", if_a.ws_allowin, 1'b1);

    // 3: r0 destination and we=0 lane produce no writes
    nxt();
    if_a.es_to_ws_valid = 2'b11;
    if_a.es_to_ws_bus   = {lane(1'b0, 5'd9, 32'h99, 32'h204), lane(1'b1, 5'd0, 32'h55, 32'h200)};
    nxt();
    if_a.es_to_ws_valid = 2'b00;
    #1;
    chk("t3_we",      if_a.rf_we,      2'b00);
    chk("t3_busy",    if_a.ws_busy,    1'b1);
    chk("t3_allowin", if_a.ws_allowin, 1'b1);
    nxt(); #1;
    chk("t3_retired", if_a.ws_busy,    1'b0);

    // 4: four writes over two ports, next group captured in the last drain cycle
    if_b.es_to_ws_valid = 4'b1111;
    if_b.es_to_ws_bus   = {lane(1'b1, 5'd4, 32'h104, 32'h30C), lane(1'b1, 5'd3, 32'h103, 32'h308),
                           lane(1'b1, 5'd2, 32'h102, 32'h304), lane(1'b1, 5'd1, 32'h101, 32'h300)};
    nxt();
    if_b.es_to_ws_valid = 4'b0001;
    if_b.es_to_ws_bus   = {lane(1'b0, 5'd0, 32'h0, 32'h0), lane(1'b0, 5'd0, 32'h0, 32'h0),
                           lane(1'b0, 5'd0, 32'h0, 32'h0), lane(1'b1, 5'd6, 32'h66, 32'h310)};
    #1;
    chk("t4_c1_we",      if_b.rf_we,      2'b11);
    chk("t4_c1_waddr",   if_b.rf_waddr,   10'h041);
    chk("t4_c1_wdata",   if_b.rf_wdata,   64'h00000102_00000101);
    chk("t4_c1_allowin", if_b.ws_allowin, 1'b0);
    nxt(); #1;
    chk("t4_c2_we",      if_b.rf_we,      2'b11);
    chk("t4_c2_waddr",   if_b.rf_waddr,   10'h083);
    chk("t4_c2_wdata",   if_b.rf_wdata,   64'h00000104_00000103);
    chk("t4_c2_pc",      if_b.rf_pc,      64'h0000030C_00000308);
    chk("t4_c2_allowin", if_b.ws_allowin, 1'b1);
    nxt();
    if_b.es_to_ws_valid = 4'b0000;
    #1;
    chk("t4_c3_we",      if_b.rf_we,      2'b01);
    chk("t4_c3_waddr",   if_b.rf_waddr,   10'h006);
    chk("t4_c3_wdata",   if_b.rf_wdata,   64'h66);
    chk("t4_c3_busy",    if_b.ws_busy,    1'b1);
    nxt(); #1;
    chk("t4_idle",       if_b.ws_busy,    1'b0);

    // squash across four lanes: only lanes 2,3 survive, in lane order on ports 0,1
    if_b.es_to_ws_valid = 4'b1111;
    if_b.es_to_ws_bus   = {lane(1'b1, 5'd2, 32'hD, 32'h40C), lane(1'b1, 5'd1, 32'hC, 32'h408),
                           lane(1'b1, 5'd2, 32'hB, 32'h404), lane(1'b1, 5'd1, 32'hA, 32'h400)};
    nxt();
    if_b.es_to_ws_valid = 4'b0000;
    #1;
    chk("sq_we",      if_b.rf_we,      2'b11);
    chk("sq_waddr",   if_b.rf_waddr,   10'h041);
    chk("sq_wdata",   if_b.rf_wdata,   64'h0000000D_0000000C);
    chk("sq_allowin", if_b.ws_allowin, 1'b1);
    nxt();

    // 5: flush in the first drain cycle kills the remaining writes
    if_b.es_to_ws_valid = 4'b1111;
    if_b.es_to_ws_bus   = {lane(1'b1, 5'd4, 32'h104, 32'h30C), lane(1'b1, 5'd3, 32'h103, 32'h308),
                           lane(1'b1, 5'd2, 32'h102, 32'h304), lane(1'b1, 5'd1, 32'h101, 32'h300)};
    nxt();
    if_b.es_to_ws_valid = 4'b0000;
    if_b.flush          = 1'b1;
    #1;
    chk("t5_flush_we",      if_b.rf_we,      2'b00);
    chk("t5_flush_allowin", if_b.ws_allowin, 1'b0);
    nxt();
    if_b.flush = 1'b0;
    #1;
    chk("t5_busy",    if_b.ws_busy,    1'b0);
    chk("t5_we",      if_b.rf_we,      2'b00);
    chk("t5_allowin", if_b.ws_allowin, 1'b1);
    nxt(); #1;
    chk("t5_we_late", if_b.rf_we,      2'b00);

    // 6: single port, reset after the first write discards the rest
    if_c.es_to_ws_valid = 4'b1111;
    if_c.es_to_ws_bus   = {lane(1'b1, 5'd4, 32'h104, 32'h30C), lane(1'b1, 5'd3, 32'h103, 32'h308),
                           lane(1'b1, 5'd2, 32'h102, 32'h304), lane(1'b1, 5'd1, 32'h101, 32'h300)};
    nxt();
    if_c.es_to_ws_valid = 4'b0000;
    #1;
    chk("t6_c1_we",      if_c.rf_we,      1'b1);
    chk("t6_c1_waddr",   if_c.rf_waddr,   5'd1);
    chk("t6_c1_wdata",   if_c.rf_wdata,   32'h101);
    chk("t6_c1_allowin", if_c.ws_allowin, 1'b0);
    nxt();
    rst_c = 1'b1;
    #1;
    chk("t6_rst_we", if_c.rf_we, 1'b0);
    nxt();
    rst_c = 1'b0;
    #1;
    chk("t6_post_we",      if_c.rf_we,      1'b0);
    chk("t6_post_allowin", if_c.ws_allowin, 1'b1);
    chk("t6_post_busy",    if_c.ws_busy,    1'b0);
    nxt(); #1;
    chk("t6_late_we", if_c.rf_we, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
